// File: rtl/snow64_instr_decoder.sv
// Registered IF/ID decoder for 32-bit Snow64 instructions (one cycle latency).
// Optional out_illegal port enabled by defining SNOW64_INSTR_DECODER_ILLEGAL_FLAG_EN.
module snow64_instr_decoder #(
  parameter int unsigned WIDTH_CPU_ADDR = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_stall,
  input  logic [31:0]               in_instr,
  output logic                      out_valid,
  output logic                      out_nop,
  output logic [3:0]                out_group,
  output logic [3:0]                out_ra_index,
  output logic [3:0]                out_rb_index,
  output logic [3:0]                out_rc_index,
  output logic [3:0]                out_oper,
  output logic [2:0]                out_op_type,
  output logic [WIDTH_CPU_ADDR-1:0] out_signext_imm
`ifdef SNOW64_INSTR_DECODER_ILLEGAL_FLAG_EN
  ,
  output logic                      out_illegal
`endif
);

  typedef enum logic [3:0] {
    GROUP_ALU   = 4'd0,
    GROUP_CTRL  = 4'd1,
    GROUP_LOAD  = 4'd2,
    GROUP_STORE = 4'd3,
    GROUP_NOP   = 4'd15
  } group_t;

  logic [3:0]                grp;
  logic [3:0]                oper;
  logic                      dec_legal;
  logic [2:0]                dec_op_type;
  logic [WIDTH_CPU_ADDR-1:0] dec_imm;

  assign grp  = in_instr[31:28];
  assign oper = in_instr[15:12];

  always_comb begin
    dec_legal   = 1'b0;
    dec_op_type = '0;
    dec_imm     = '0;
    case (grp)
      GROUP_ALU: begin
        dec_legal   = 1'b1;
        dec_op_type = in_instr[11:9];
      end
      GROUP_CTRL: begin
        dec_legal = ~oper[3];
        dec_imm   = WIDTH_CPU_ADDR'($signed(in_instr[11:0]));
      end
      GROUP_LOAD, GROUP_STORE: begin
        dec_legal   = ~oper[3];
        dec_op_type = in_instr[11:9];
        dec_imm     = WIDTH_CPU_ADDR'($signed(in_instr[8:0]));
      end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef SNOW64_INSTR_DECODER_ILLEGAL_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_illegal <= 1'b0;
    end else if (!in_stall) begin
      out_illegal <= in_valid && !dec_legal && (grp != GROUP_NOP);
    end
  end
`endif

  // Reset and bubble share one output state: invalid, nop, every field zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_nop         <= 1'b1;
      out_group       <= '0;
      out_ra_index    <= '0;
      out_rb_index    <= '0;
      out_rc_index    <= '0;
      out_oper        <= '0;
      out_op_type     <= '0;
      out_signext_imm <= '0;
    end else if (!in_stall) begin
      out_valid <= in_valid;
      if (in_valid && dec_legal) begin
        out_nop         <= 1'b0;
        out_group       <= grp;
        out_ra_index    <= in_instr[27:24];
        out_rb_index    <= in_instr[23:20];
        out_rc_index    <= in_instr[19:16];
        out_oper        <= oper;
        out_op_type     <= dec_op_type;
        out_signext_imm <= dec_imm;
      end else begin
        out_nop         <= 1'b1;
        out_group       <= in_valid ? grp : '0;
        out_ra_index    <= '0;
        out_rb_index    <= '0;
        out_rc_index    <= '0;
        out_oper        <= '0;
        out_op_type     <= '0;
        out_signext_imm <= '0;
      end
    end
  end

endmodule

// File: tb/tb_snow64_instr_decoder.sv
// Self-checking bench for snow64_instr_decoder: directed vector table, stall/reset
// sequences and randomized traffic against a behavioural model.
module tb_snow64_instr_decoder;

  typedef struct packed {
    logic        valid;
    logic        nop;
    logic [3:0]  group;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  oper;
    logic [2:0]  op_type;
    logic [63:0] imm;
    logic        illegal;
  } out_t;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_stall;
  logic [31:0] in_instr;
  logic        out_valid, out_nop;
  logic [3:0]  out_group, out_ra_index, out_rb_index, out_rc_index, out_oper;
  logic [2:0]  out_op_type;
  logic [63:0] out_signext_imm;
  logic        act_illegal;

  int unsigned passed = 0;
  int unsigned total  = 0;
  vec_t        vecs[$];
  out_t        model_q;

  always #5 clk = ~clk;

  snow64_instr_decoder #(.WIDTH_CPU_ADDR(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_stall(in_stall), .in_instr(in_instr),
    .out_valid(out_valid), .out_nop(out_nop), .out_group(out_group),
    .out_ra_index(out_ra_index), .out_rb_index(out_rb_index), .out_rc_index(out_rc_index),
    .out_oper(out_oper), .out_op_type(out_op_type), .out_signext_imm(out_signext_imm)
`ifdef SNOW64_INSTR_DECODER_ILLEGAL_FLAG_EN
    , .out_illegal(act_illegal)
`endif
  );

`ifndef SNOW64_INSTR_DECODER_ILLEGAL_FLAG_EN
  assign act_illegal = 1'b0;
`endif

  function automatic out_t mk(input logic v, input logic n, input logic [3:0] g, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c, input logic [3:0] o,
                              input logic [2:0] t, input logic [63:0] imm, input logic ill);
    out_t r;
    r.valid = v; r.nop = n; r.group = g; r.ra = a; r.rb = b; r.rc = c;
    r.oper = o; r.op_type = t; r.imm = imm;
`ifdef SNOW64_INSTR_DECODER_ILLEGAL_FLAG_EN
    r.illegal = ill;
`else
    r.illegal = 1'b0 & ill;
`endif
    return r;
  endfunction

  function automatic out_t idle_out();
    return mk(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 64'd0, 1'b0);
  endfunction

  // Decoding rules written as plain arithmetic on the instruction word.
  function automatic out_t model_decode(input logic [31:0] instr);
    int unsigned g, o, v;
    int          s;
    bit          legal;
    out_t        r;
    g = instr >> 28;
    o = (instr >> 12) % 16;
    legal = (g == 0) || (g >= 1 && g <= 3 && o < 8);
    if (!legal)
      return mk(1'b1, 1'b1, 4'(g), 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 64'd0, g != 15);
    s = 0;
    if (g == 1) begin
      v = instr % 4096;
      s = (v >= 2048) ? int'(v) - 4096 : int'(v);
    end else if (g != 0) begin
      v = instr % 512;
      s = (v >= 256) ? int'(v) - 512 : int'(v);
    end
    r = mk(1'b1, 1'b0, 4'(g), 4'((instr >> 24) % 16), 4'((instr >> 20) % 16),
           4'((instr >> 16) % 16), 4'(o), (g == 1) ? 3'd0 : 3'((instr >> 9) % 8),
           64'(longint'(s)), 1'b0);
    return r;
  endfunction

  function automatic out_t model_step(input out_t cur, input logic r, input logic st,
                                      input logic v, input logic [31:0] instr);
    if (r)  return idle_out();
    if (st) return cur;
    if (v)  return model_decode(instr);
    return idle_out();
  endfunction

  function automatic out_t sample();
    return mk(out_valid, out_nop, out_group, out_ra_index, out_rb_index, out_rc_index,
              out_oper, out_op_type, out_signext_imm, act_illegal);
  endfunction

  task automatic drive_and_check(input string name, input int idx, input logic r, input logic st,
                                 input logic v, input logic [31:0] instr, input out_t exp);
    out_t act;
    @(negedge clk);
    rst = r; in_stall = st; in_valid = v; in_instr = instr;
    @(posedge clk);
    #1;
    act = sample();
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic add(input logic r, input logic st, input logic v, input logic [31:0] instr,
                     input out_t exp);
    vec_t e;
    e.rst = r; e.stall = st; e.valid = v; e.instr = instr; e.exp = exp;
    vecs.push_back(e);
  endtask

  initial begin
    out_t alu, br, ld, st_o;
    alu  = mk(1, 0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 3'd5, 64'd0, 0);
    br   = mk(1, 0, 4'd1, 4'd4, 4'd5, 4'd0, 4'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    ld   = mk(1, 0, 4'd2, 4'd6, 4'd7, 4'd0, 4'd3, 3'd7, 64'h10, 0);
    st_o = mk(1, 0, 4'd3, 4'd6, 4'd7, 4'd0, 4'd3, 3'd7, 64'h10, 0);

    add(1, 0, 1, 32'h2670_3E10, idle_out());
    add(0, 0, 1, 32'h0123_5A00, alu);
    add(0, 0, 1, 32'h1450_2FFC, br);
    add(0, 0, 1, 32'h2670_3E10, ld);
    add(0, 0, 1, 32'h3670_3E10, st_o);
    add(0, 0, 1, 32'h7000_0000, mk(1, 1, 4'd7, 0, 0, 0, 0, 0, 64'd0, 1));
    add(0, 0, 1, 32'h1000_9000, mk(1, 1, 4'd1, 0, 0, 0, 0, 0, 64'd0, 1));
    add(0, 0, 1, 32'hF123_4567, mk(1, 1, 4'd15, 0, 0, 0, 0, 0, 64'd0, 0));
    add(0, 0, 0, 32'h0123_5A00, idle_out());
    add(0, 0, 1, 32'h0123_5A00, alu);
    add(0, 1, 1, 32'h1450_2FFC, alu);
    add(0, 1, 1, 32'h1450_2FFC, alu);
    add(0, 1, 1, 32'h1450_2FFC, alu);
    add(0, 0, 1, 32'h1450_2FFC, br);
    add(1, 0, 1, 32'h2670_3E10, idle_out());
    add(0, 0, 0, 32'h2670_3E10, idle_out());
    add(0, 0, 1, 32'h2670_3E10, ld);
    add(1, 1, 1, 32'h0123_5A00, idle_out());
    add(0, 0, 1, 32'h1FFF_7800, mk(1, 0, 4'd1, 4'hF, 4'hF, 4'hF, 4'd7, 3'd0, 64'hFFFF_FFFF_FFFF_F800, 0));
    add(0, 0, 1, 32'h2000_71FF, mk(1, 0, 4'd2, 0, 0, 0, 4'd7, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    add(0, 0, 1, 32'h3000_80FF, mk(1, 1, 4'd3, 0, 0, 0, 0, 0, 64'd0, 1));
    add(0, 0, 1, 32'h0ABC_F000, mk(1, 0, 4'd0, 4'hA, 4'hB, 4'hC, 4'hF, 3'd0, 64'd0, 0));
    add(0, 1, 0, 32'h0000_0000, mk(1, 0, 4'd0, 4'hA, 4'hB, 4'hC, 4'hF, 3'd0, 64'd0, 0));

    rst = 1; in_stall = 0; in_valid = 0; in_instr = '0;
    repeat (2) @(posedge clk);

    foreach (vecs[i])
      drive_and_check("table", i, vecs[i].rst, vecs[i].stall, vecs[i].valid, vecs[i].instr, vecs[i].exp);

    // Hand sequence: stall right after a reserved word keeps it, then reset mid-stream.
    model_q = idle_out();
    drive_and_check("seq_rst", 0, 1, 0, 0, 32'h0, idle_out());
    drive_and_check("seq_res", 1, 0, 0, 1, 32'h9555_5555, mk(1, 1, 4'd9, 0, 0, 0, 0, 0, 64'd0, 1));
    drive_and_check("seq_hold", 2, 0, 1, 1, 32'h0123_5A00, mk(1, 1, 4'd9, 0, 0, 0, 0, 0, 64'd0, 1));
    drive_and_check("seq_midrst", 3, 1, 0, 1, 32'h0123_5A00, idle_out());

    for (int i = 0; i < 400; i++) begin
      logic        r, s, v;
      logic [31:0] instr;
      int unsigned pick;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 4) != 0);
      instr = $urandom;
      pick = $urandom_range(0, 5);
      if (pick < 4) instr[31:28] = 4'(pick);
      else if (pick == 4) instr[31:28] = 4'hF;
      model_q = model_step(model_q, r, s, v, instr);
      drive_and_check("random", i, r, s, v, instr, model_q);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
